instruction_fetch_phase: RTL and testbench

Pipeline IF stage and IF/ID register. It is the producer end of the decode stage's `instr_in`/`pc_in` interface and the consumer of its redirect outputs (Jump, taken Branch, JumpRegister target). It owns the PC and drives a request/acknowledge instruction-memory port that tolerates variable latency. It also supports hazard stalls and control-flow flushes.

---
 rtl/instruction_fetch_phase.sv | 151 +++++++++++++++
 tb/tb_instruction_fetch_phase.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_phase.sv
// IF stage and IF/ID register with a request/acknowledge instruction-memory port.
// Defining FETCH_PERF_CNT_EN adds saturating fetch and stall counters.
module instruction_fetch_phase #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HELD,
        DISCARD
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic [31:0] pending_target;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        deliver;
    logic [31:0] deliver_word;

    assign target   = RedirectTarget & 32'hFFFF_FFFC;
    assign pc_plus4 = pc + 32'd4;

    // In DISCARD the PC is left untouched, so it still names the outstanding request.
    assign imem_req  = (state == FETCH) || (state == DISCARD);
    assign imem_addr = pc;

    always_comb begin
        deliver      = 1'b0;
        deliver_word = imem_rdata;
        if (!Redirect && !Stall) begin
            if (state == FETCH && imem_ack) begin
                deliver = 1'b1;
            end else if (state == HELD) begin
                deliver      = 1'b1;
                deliver_word = hold_buf;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            pc             <= RESET_PC & 32'hFFFF_FFFC;
            instr_out      <= NOP_INSTR;
            pc_out         <= 32'h0;
            valid_out      <= 1'b0;
            hold_buf       <= 32'h0;
            pending_target <= 32'h0;
        end else begin
            if (deliver) begin
                instr_out <= deliver_word;
                pc_out    <= pc_plus4;
                valid_out <= 1'b1;
                pc        <= pc_plus4;
            end
            case (state)
                IDLE: begin
                    state <= FETCH;
                    if (Redirect) begin
                        pc        <= target;
                        instr_out <= NOP_INSTR;
                        valid_out <= 1'b0;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (Redirect) begin
                            pc        <= target;
                            instr_out <= NOP_INSTR;
                            valid_out <= 1'b0;
                        end else if (Stall) begin
                            hold_buf <= imem_rdata;
                            state    <= HELD;
                        end
                    end else if (Redirect) begin
                        // The in-flight word must still be absorbed before the target can issue.
                        pending_target <= target;
                        instr_out      <= NOP_INSTR;
                        valid_out      <= 1'b0;
                        state          <= DISCARD;
                    end else if (!Stall) begin
                        instr_out <= NOP_INSTR;
                        valid_out <= 1'b0;
                    end
                end
                HELD: begin
                    if (Redirect) begin
                        pc        <= target;
                        instr_out <= NOP_INSTR;
                        valid_out <= 1'b0;
                        state     <= FETCH;
                    end else if (!Stall) begin
                        state <= FETCH;
                    end
                end
                DISCARD: begin
                    if (Redirect) begin
                        instr_out <= NOP_INSTR;
                        valid_out <= 1'b0;
                    end
                    if (imem_ack) begin
                        pc    <= Redirect ? target : pending_target;
                        state <= FETCH;
                    end else if (Redirect) begin
                        pending_target <= target;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (deliver && fetch_count != 32'hFFFF_FFFF) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (Stall && stall_count != 32'hFFFF_FFFF) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_phase.sv
// Bench for instruction_fetch_phase: directed vector table, then random traffic
// checked against a transaction-level model of the fetch stage.
module tb_instruction_fetch_phase;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    instruction_fetch_phase dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Stall          (Stall),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .valid_out      (valid_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    // Transaction-level model: where the next fetch goes, what is parked, what is being thrown away.
    bit          m_idle;
    bit          m_holding;
    bit          m_dropping;
    logic [31:0] m_pc;
    logic [31:0] m_held;
    logic [31:0] m_pending;
    logic [31:0] m_instr;
    logic [31:0] m_pcout;
    bit          m_valid;
    int unsigned m_fetches;
    int unsigned m_stalls;

    function automatic void model_reset();
        m_idle     = 1'b1;
        m_holding  = 1'b0;
        m_dropping = 1'b0;
        m_pc       = 32'h0;
        m_held     = 32'h0;
        m_pending  = 32'h0;
        m_instr    = 32'h0;
        m_pcout    = 32'h0;
        m_valid    = 1'b0;
        m_fetches  = 0;
        m_stalls   = 0;
    endfunction

    function automatic void model_bubble();
        m_instr = 32'h0;
        m_valid = 1'b0;
    endfunction

    function automatic void model_deliver(input logic [31:0] w);
        m_instr = w;
        m_pcout = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
        m_fetches++;
    endfunction

    function automatic void model_update(input bit stall, input bit redir,
                                         input logic [31:0] tgt, input bit ack,
                                         input logic [31:0] rdata);
        logic [31:0] t;
        t = {tgt[31:2], 2'b00};
        if (stall) m_stalls++;
        if (m_idle) begin
            m_idle = 1'b0;
            if (redir) begin
                m_pc = t;
                model_bubble();
            end
        end else if (m_holding) begin
            if (redir) begin
                m_pc      = t;
                m_holding = 1'b0;
                model_bubble();
            end else if (!stall) begin
                m_holding = 1'b0;
                model_deliver(m_held);
            end
        end else if (m_dropping) begin
            if (redir) model_bubble();
            if (ack) begin
                m_pc       = redir ? t : m_pending;
                m_dropping = 1'b0;
            end else if (redir) begin
                m_pending = t;
            end
        end else if (ack) begin
            if (redir) begin
                m_pc = t;
                model_bubble();
            end else if (stall) begin
                m_held    = rdata;
                m_holding = 1'b1;
            end else begin
                model_deliver(rdata);
            end
        end else if (redir) begin
            m_pending  = t;
            m_dropping = 1'b1;
            model_bubble();
        end else if (!stall) begin
            model_bubble();
        end
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h8C00_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_model(input string tag);
        bit exp_req;
        exp_req = !m_idle && !m_holding;
        check({tag, " imem_req"}, {31'h0, imem_req}, {31'h0, exp_req});
        if (exp_req) check({tag, " imem_addr"}, imem_addr, m_pc);
        check({tag, " valid_out"}, {31'h0, valid_out}, {31'h0, m_valid});
        check({tag, " instr_out"}, instr_out, m_instr);
        if (m_valid) check({tag, " pc_out"}, pc_out, m_pcout);
    endtask

    // Drive one cycle of inputs, advance past the edge, and keep the model in step.
    task automatic step(input bit stall, input bit redir, input logic [31:0] tgt,
                        input bit ack, input logic [31:0] rdata);
        Stall          = stall;
        Redirect       = redir;
        RedirectTarget = tgt;
        imem_ack       = ack;
        imem_rdata     = rdata;
        @(posedge Clk);
        model_update(stall, redir, tgt, ack, rdata);
        @(negedge Clk);
    endtask

    typedef struct packed {
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pcout;
    } vec_t;

    function automatic vec_t mk(input logic stall, input logic redir, input logic [31:0] tgt,
                                input logic ack, input logic [31:0] rdata,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_instr,
                                input logic [31:0] e_pcout);
        vec_t v;
        v.stall = stall; v.redir = redir; v.tgt = tgt; v.ack = ack; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pcout = e_pcout;
        return v;
    endfunction

    vec_t vecs[20];

    initial begin
        vecs[0]  = mk(0, 0, 32'h0,        1, 32'h8C01_0000, 0, 32'h0,        0, 32'h0,        32'h0);
        vecs[1]  = mk(0, 0, 32'h0,        1, 32'h8C01_0000, 1, 32'h0,        0, 32'h0,        32'h0);
        vecs[2]  = mk(0, 0, 32'h0,        1, 32'h2001_0001, 1, 32'h4,        1, 32'h8C01_0000, 32'h4);
        vecs[3]  = mk(1, 0, 32'h0,        1, 32'hAC01_0000, 1, 32'h8,        1, 32'h2001_0001, 32'h8);
        vecs[4]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h8,        1, 32'h2001_0001, 32'h8);
        vecs[5]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h8,        1, 32'h2001_0001, 32'h8);
        vecs[6]  = mk(0, 0, 32'h0,        1, 32'h2402_0005, 1, 32'hC,        1, 32'hAC01_0000, 32'hC);
        vecs[7]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       1, 32'h2402_0005, 32'h10);
        vecs[8]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       0, 32'h0,        32'h0);
        vecs[9]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       0, 32'h0,        32'h0);
        vecs[10] = mk(0, 0, 32'h0,        1, 32'h3C01_1234, 1, 32'h10,       0, 32'h0,        32'h0);
        vecs[11] = mk(0, 1, 32'h43,       0, 32'h0,        1, 32'h14,       1, 32'h3C01_1234, 32'h14);
        vecs[12] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h14,       0, 32'h0,        32'h0);
        vecs[13] = mk(0, 0, 32'h0,        1, 32'hDEAD_BEEF, 1, 32'h14,       0, 32'h0,        32'h0);
        vecs[14] = mk(0, 0, 32'h0,        1, 32'h1111_2222, 1, 32'h40,       0, 32'h0,        32'h0);
        vecs[15] = mk(1, 1, 32'hFFFF_FFFD, 0, 32'h0,        1, 32'h44,       1, 32'h1111_2222, 32'h44);
        vecs[16] = mk(0, 0, 32'h0,        1, 32'hCAFE_F00D, 1, 32'h44,       0, 32'h0,        32'h0);
        vecs[17] = mk(0, 0, 32'h0,        1, 32'h0BAD_F00D, 1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0);
        vecs[18] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 32'h0BAD_F00D, 32'h0);
        vecs[19] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);

        Reset          = 1'b1;
        Stall          = 1'b0;
        Redirect       = 1'b0;
        RedirectTarget = 32'h0;
        imem_ack       = 1'b1;
        imem_rdata     = 32'h8C01_0000;
        model_reset();
        #3;
        check("reset imem_req", {31'h0, imem_req}, 32'h0);
        check("reset valid_out", {31'h0, valid_out}, 32'h0);
        check("reset instr_out", instr_out, 32'h0);
        check("reset pc_out", pc_out, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            check({tag, " imem_req"}, {31'h0, imem_req}, {31'h0, vecs[i].e_req});
            if (vecs[i].e_req) check({tag, " imem_addr"}, imem_addr, vecs[i].e_addr);
            check({tag, " valid_out"}, {31'h0, valid_out}, {31'h0, vecs[i].e_valid});
            check({tag, " instr_out"}, instr_out, vecs[i].e_instr);
            if (vecs[i].e_valid) check({tag, " pc_out"}, pc_out, vecs[i].e_pcout);
            step(vecs[i].stall, vecs[i].redir, vecs[i].tgt, vecs[i].ack, vecs[i].rdata);
        end
`ifdef FETCH_PERF_CNT_EN
        check("table fetch_count", fetch_count, 32'd7);
        check("table stall_count", stall_count, 32'd3);
`endif

        for (int c = 0; c < 1500; c++) begin
            bit          st;
            bit          rd;
            bit          ak;
            logic [31:0] tg;
            logic [31:0] dat;
            check_model($sformatf("rnd%0d", c));
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            tg  = $urandom;
            ak  = !m_idle && !m_holding && ($urandom_range(0, 1) == 1);
            dat = ak ? mem_word(m_pc) : $urandom;
            step(st, rd, tg, ak, dat);
        end
        check_model("rnd end");
`ifdef FETCH_PERF_CNT_EN
        check("rnd fetch_count", fetch_count, m_fetches);
        check("rnd stall_count", stall_count, m_stalls);
`endif

        // Asynchronous reset in the middle of a cycle with a request outstanding.
        Stall    = 1'b0;
        Redirect = 1'b0;
        imem_ack = 1'b0;
        @(posedge Clk);
        model_update(1'b0, 1'b0, RedirectTarget, 1'b0, imem_rdata);
        #2;
        Reset = 1'b1;
        #1;
        check("async reset imem_req", {31'h0, imem_req}, 32'h0);
        check("async reset valid_out", {31'h0, valid_out}, 32'h0);
        check("async reset instr_out", instr_out, 32'h0);
        check("async reset pc_out", pc_out, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("async reset fetch_count", fetch_count, 32'h0);
        check("async reset stall_count", stall_count, 32'h0);
`endif
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        check("post reset idle imem_req", {31'h0, imem_req}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("post reset imem_req", {31'h0, imem_req}, 32'h1);
        check("post reset imem_addr", imem_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
        check("post reset instr_out", instr_out, 32'h1234_5678);
        check("post reset pc_out", pc_out, 32'h4);
        check("post reset valid_out", {31'h0, valid_out}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
